// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the CPU/host memory port arbiter.
// State encoding, requester ids and default RAM size.
package mem_port_arbiter_pkg;

  localparam int DEF_WORD_AW = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    HOST_RD = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
// Ties go to whoever was not granted most recently.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_cpu,
  input  logic req_host,
  output logic gnt_cpu,
  output logic gnt_host
);

  req_id_t last;
  logic    host_wins;

  assign host_wins = req_host &&
                     (!req_cpu || last == REQ_CPU);
  assign gnt_host  = en && host_wins;
  assign gnt_cpu   = en && req_cpu && !host_wins;

  // Remember the most recent winner on every grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= REQ_CPU;
    end else if (gnt_host) begin
      last <= REQ_HOST;
    end else if (gnt_cpu) begin
      last <= REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word RAM between a CPU word port and a host byte port.
// Writes complete in the grant cycle; reads return one cycle later.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int WORD_AW = DEF_WORD_AW,
  localparam int BYTE_AW = WORD_AW + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [WORD_AW-1:0] cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic [31:0]        cpu_rdata,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [BYTE_AW-1:0] host_addr,
  input  logic [7:0]         host_wdata,
  output logic               host_gnt,
  output logic               host_rvalid,
  output logic [7:0]         host_rdata,
  output logic               ram_we,
  output logic [3:0]         ram_be,
  output logic [WORD_AW-1:0] ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  state_t      state;
  logic [1:0]  lane_q;
  logic [31:0] cpu_rdata_q;
  logic [7:0]  host_rdata_q;
  logic [7:0]  rd_byte;
  logic        idle;

  assign idle = (state == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (idle),
    .req_cpu  (cpu_req),
    .req_host (host_req),
    .gnt_cpu  (cpu_gnt),
    .gnt_host (host_gnt)
  );

  assign rd_byte     = ram_rdata[{lane_q, 3'b000} +: 8];
  assign cpu_rvalid  = (state == CPU_RD) && !rst;
  assign host_rvalid = (state == HOST_RD) && !rst;

  // Data is live in the response cycle, then the captured copy holds
  assign cpu_rdata  = rst         ? 32'd0 :
                      cpu_rvalid  ? ram_rdata : cpu_rdata_q;
  assign host_rdata = rst         ? 8'd0 :
                      host_rvalid ? rd_byte : host_rdata_q;

  // Steer the granted requester onto the RAM port
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    unique case (1'b1)
      cpu_gnt: begin
        ram_we = cpu_we;
        ram_be = cpu_we ? 4'b1111 : 4'b0000;
      end
      host_gnt: begin
        ram_addr  = host_addr[BYTE_AW-1:2];
        ram_wdata = {4{host_wdata}};
        ram_we    = host_we;
        ram_be    = host_we ? (4'b0001 << host_addr[1:0])
                            : 4'b0000;
      end
      default: ;
    endcase
  end

  // Read sequencing, lane capture and response hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lane_q       <= 2'd0;
      cpu_rdata_q  <= 32'd0;
      host_rdata_q <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_gnt && !cpu_we) begin
            state <= CPU_RD;
          end else if (host_gnt && !host_we) begin
            state  <= HOST_RD;
            lane_q <= host_addr[1:0];
          end
        end
        CPU_RD: begin
          state       <= IDLE;
          cpu_rdata_q <= ram_rdata;
        end
        HOST_RD: begin
          state        <= IDLE;
          host_rdata_q <= rd_byte;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic.
// A byte-level reference memory and arbitration model predict outputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        host_req, host_we;
  logic [6:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt, host_rvalid;
  logic [7:0]  host_rdata;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .ram_we      (ram_we),
    .ram_be      (ram_be),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // Synchronous RAM with byte enables, one-cycle read latency
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    ram_rdata = 32'd0;
  end
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we && ram_be[b])
        mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  // Reference model state
  logic [7:0]  refmem [128];
  int          busy;
  int          last;
  logic [4:0]  rd_w;
  logic [6:0]  rd_b;
  logic [31:0] hold_c;
  logic [7:0]  hold_h;
  logic        g_cpu, g_host;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [4:0] w);
    return {refmem[{w, 2'd3}], refmem[{w, 2'd2}],
            refmem[{w, 2'd1}], refmem[{w, 2'd0}]};
  endfunction

  task automatic model_reset();
    busy   = 0;
    last   = 0;
    hold_c = 32'd0;
    hold_h = 8'd0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cpu_req = 1'b0;
    host_req = 1'b0;
    repeat (n) begin
      #3;
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_host_gnt", host_gnt, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_host_rvalid", host_rvalid, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_be", ram_be, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_host_rdata", host_rdata, 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive requests, predict and check, then advance
  task automatic cyc(input logic cr, input logic cw,
                     input logic [4:0] ca, input logic [31:0] cd,
                     input logic hr, input logic hw,
                     input logic [6:0] ha, input logic [7:0] hd);
    int win;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #3;
    win = -1;
    if (busy == 0) begin
      if (cr && hr) win = (last == 0) ? 1 : 0;
      else if (cr) win = 0;
      else if (hr) win = 1;
    end
    chk("cpu_gnt", cpu_gnt, win == 0);
    chk("host_gnt", host_gnt, win == 1);
    chk("cpu_rvalid", cpu_rvalid, busy == 1);
    chk("host_rvalid", host_rvalid, busy == 2);
    if (busy == 1) hold_c = ref_word(rd_w);
    if (busy == 2) hold_h = refmem[rd_b];
    chk("cpu_rdata", cpu_rdata, hold_c);
    chk("host_rdata", host_rdata, hold_h);
    if (win == 0) begin
      chk("ram_addr_cpu", ram_addr, ca);
      chk("ram_we_cpu", ram_we, cw);
      chk("ram_be_cpu", ram_be, cw ? 4'hF : 4'h0);
      if (cw) begin
        chk("ram_wdata_cpu", ram_wdata, cd);
        for (int b = 0; b < 4; b++)
          refmem[{ca, 2'(b)}] = cd[8*b +: 8];
      end
    end else if (win == 1) begin
      chk("ram_addr_host", ram_addr, ha / 4);
      chk("ram_we_host", ram_we, hw);
      chk("ram_be_host", ram_be, hw ? (1 << (ha % 4)) : 0);
      if (hw) begin
        chk("ram_wdata_host", ram_wdata, {hd, hd, hd, hd});
        refmem[ha] = hd;
      end
    end else begin
      chk("ram_we_idle", ram_we, 0);
      chk("ram_be_idle", ram_be, 0);
    end
    g_cpu  = cpu_gnt;
    g_host = host_gnt;
    if (busy != 0) busy = 0;
    else if (win == 0 && !cw) begin busy = 1; rd_w = ca; end
    else if (win == 1 && !hw) begin busy = 2; rd_b = ha; end
    if (win >= 0) last = win;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 5'd0, 32'd0, 0, 0, 7'd0, 8'd0);
  endtask

  logic        cp, hp, cw_r, hw_r;
  logic [4:0]  ca_r;
  logic [31:0] cd_r;
  logic [6:0]  ha_r;
  logic [7:0]  hd_r;

  initial begin
    for (int i = 0; i < 128; i++) refmem[i] = 8'd0;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // Both writing continuously: H,C,H,C from reset
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 5'd9, 32'hCAFE0000 + i, 1, 1, 7'd40, 8'(i));
      chk("rr_host_seq", g_host, (i % 2) == 0);
      chk("rr_cpu_seq", g_cpu, (i % 2) == 1);
    end

    // Host byte write then CPU word read of the same word
    cyc(0, 0, 5'd0, 32'd0, 1, 1, 7'h05, 8'hAB);
    cyc(1, 0, 5'd1, 32'd0, 0, 0, 7'd0, 8'd0);
    chk("req043_byte", cpu_rdata[15:8], 8'hAB);
    idle_cyc();

    // CPU word write then host byte read of lane 2
    cyc(1, 1, 5'd3, 32'h11223344, 0, 0, 7'd0, 8'd0);
    cyc(0, 0, 5'd0, 32'd0, 1, 0, 7'h0E, 8'd0);
    chk("req044_byte", host_rdata, 8'h22);
    idle_cyc();

    // CPU request arriving during a host read waits one cycle
    cyc(0, 0, 5'd0, 32'd0, 1, 0, 7'h0E, 8'd0);
    cyc(1, 0, 5'd3, 32'd0, 0, 0, 7'd0, 8'd0);
    chk("req046_held", g_cpu, 0);
    cyc(1, 0, 5'd3, 32'd0, 0, 0, 7'd0, 8'd0);
    chk("req046_gnt", g_cpu, 1);
    idle_cyc();

    // Four host byte writes assemble a word
    cyc(0, 0, 5'd0, 32'd0, 1, 1, 7'h00, 8'hDE);
    cyc(0, 0, 5'd0, 32'd0, 1, 1, 7'h01, 8'hAD);
    cyc(0, 0, 5'd0, 32'd0, 1, 1, 7'h02, 8'hBE);
    cyc(0, 0, 5'd0, 32'd0, 1, 1, 7'h03, 8'hEF);
    cyc(1, 0, 5'd0, 32'd0, 0, 0, 7'd0, 8'd0);
    chk("req048_word", cpu_rdata, 32'hEFBEADDE);
    idle_cyc();

    // Reset in the response cycle drops the read
    cyc(1, 0, 5'd0, 32'd0, 0, 0, 7'd0, 8'd0);
    do_reset(1);
    cyc(1, 1, 5'd4, 32'h0BADF00D, 1, 1, 7'h11, 8'h5A);
    chk("req047_tie_host", g_host, 1);

    // Random traffic, each request held until granted
    cp = 0; hp = 0;
    cw_r = 0; hw_r = 0; ca_r = 0; cd_r = 0; ha_r = 0; hd_r = 0;
    for (int i = 0; i < 400; i++) begin
      if (!cp && $urandom_range(0, 1) == 1) begin
        cp   = 1;
        cw_r = 1'($urandom_range(0, 1));
        ca_r = 5'($urandom_range(0, 31));
        cd_r = $urandom;
      end
      if (!hp && $urandom_range(0, 1) == 1) begin
        hp   = 1;
        hw_r = 1'($urandom_range(0, 1));
        ha_r = 7'($urandom_range(0, 127));
        hd_r = 8'($urandom_range(0, 255));
      end
      cyc(cp, cw_r, ca_r, cd_r, hp, hw_r, ha_r, hd_r);
      if (g_cpu) cp = 0;
      if (g_host) hp = 0;
    end
    idle_cyc();
    idle_cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
